// File: rtl/relprime_controller.sv
// Finds the smallest m >= M_START with gcd(n, m) == 1 using a subtractive-Euclid datapath.
// Latency: 1 + sum over candidates of (3 + subtraction steps) edges; start ignored while busy.
module relprime_controller #(
    parameter int WIDTH   = 16,
    parameter int M_START = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] tries
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GCD,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] M_INIT   = WIDTH'(M_START);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_r_q, n_r_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] tries_q, tries_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        n_r_d    = n_r_q;
        m_d      = m_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        tries_d  = tries_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_r_d   = n_in;
                    m_d     = M_INIT;
                    tries_d = '0;
                    err_d   = 1'b0;
                    if (n_in == '0) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                a_d     = n_r_q;
                b_d     = m_q;
                tries_d = tries_q + ONE;
                state_d = S_GCD;
            end
            S_GCD: begin
                if (a_q == b_q) begin
                    state_d = S_CHECK;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            S_CHECK: begin
                if (a_q == ONE) begin
                    result_d = m_q;
                    state_d  = S_DONE;
                end else if (m_q == ALL_ONES) begin
                    // Candidate space exhausted; stop rather than wrap back to zero.
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    m_d     = m_q + ONE;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            n_r_q    <= '0;
            m_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            tries_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_r_q    <= n_r_d;
            m_q      <= m_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            tries_q  <= tries_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign tries  = tries_q;

endmodule

// File: doc/relprime_controller.md
Name: relprime_controller

Overview:
- Sequencing controller for the relprime computation: returns the smallest m >= M_START with gcd(n, m) == 1.
- Accepts a start pulse and an operand n, then iterates candidate m values.
- Computes each gcd with an internal subtractive-Euclid datapath; returns m on a one-cycle done pulse.
- Sits between the top-level start/register_value interface and the result register that feeds `out`.

Parameters:
- WIDTH, 16, operand/result width in bits.
- M_START, 2, first candidate m; must be >= 1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- n_in  input  WIDTH  operand n; captured on the accepting edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result and err are valid while high.
- err  output  1  high with done when no valid result exists.
- result  output  WIDTH  relprime(n); held until the next accepted start.
- tries  output  WIDTH  number of candidates tested for the last operation.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE.
  - busy, done, err = 0.
  - result, tries, n_r, m, a, b = 0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, LOAD, GCD, CHECK, DONE.
- IDLE:
  - start == 1: n_r <= n_in, m <= M_START, tries <= 0, err <= 0.
    - n_in == 0: result <= 0, err <= 1, go to DONE.
    - Otherwise: go to LOAD.
  - start == 0: stay in IDLE.
- LOAD: a <= n_r, b <= m, tries <= tries + 1, go to GCD.
- GCD (one subtraction per cycle):
  - a == b: go to CHECK.
  - a > b: a <= a - b.
  - a < b: b <= b - a.
  - All subtraction is unsigned WIDTH-bit. Both operands are nonzero on entry (n_r != 0, m >= 1), so no underflow or infinite loop is possible.
- CHECK (a holds gcd):
  - a == 1: result <= m, go to DONE.
  - a != 1 and m == all-ones: result <= 0, err <= 1, go to DONE. This guards against candidate wrap-around.
  - Otherwise: m <= m + 1, go to LOAD.
- DONE: done = 1 for exactly this cycle, then go to IDLE.
  - The start-acceptance window opens the cycle after done.
  - A start that is high during DONE is not accepted.
- busy is registered and high from the edge after start is accepted through the DONE cycle inclusive.
- start while busy is ignored; n_in changes while busy have no effect.
- start held high continuously: a new operation is accepted in each IDLE cycle, i.e. back-to-back operations.
- Latency for n = 1:
  - Edge 0 accepts start.
  - Edges 1 (LOAD), 2 (GCD subtract), 3 (GCD equal) and 4 (CHECK) follow.
  - done is high after edge 4 (DONE state).
  - General latency: 1 + sum over candidates of (2 + subtraction steps + 1) edges.
- Outputs result, err and tries are registered and stable from DONE until the next accepted start.

Test Plan:
- Reset then n_in = 16500, start pulsed high for 1 cycle:
  - done pulses once; result = 7, tries = 6, err = 0.
  - busy is low before start and after done.
- n_in = 1, start pulsed:
  - done is high exactly after the 4th edge following the accepting edge.
  - result = 2, tries = 1.
- n_in = 30030 (2*3*5*7*11*13): result = 17, tries = 16.
- n_in = 0: the next cycle is DONE with done = 1, err = 1, result = 0, tries = 0; no GCD cycles occur.
- n_in = 13, then start re-pulsed and n_in changed to 99 mid-run:
  - The second start is ignored; result = 2.
  - After done, start with n_in = 2 gives result = 3.
- n_in = 16500, RST_N driven low for 1 cycle while in GCD:
  - All outputs go to 0 asynchronously; no done pulse occurs.
  - After release, a new start with n_in = 9 gives result = 2.
